data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_pkg.sv | 18 +
 rtl/rr_arbiter2.sv | 45 ++++
 rtl/data_mem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and requester IDs.
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // Port ID encoded by a one-hot two-way grant.
    function automatic logic port_of_grant(input logic [1:0] gnt_oh);
        return gnt_oh[1];
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin tie-break with a last-grant register (resets so port 0 wins first).
module rr_arbiter2
    import data_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_q;
    logic last_d;

    // One-hot grant from current requests and last winner
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_q == PORT0) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // Remember the winner only when the grant is actually taken
    always_comb begin
        last_d = last_q;
        if (advance && (req != 2'b00)) begin
            last_d = port_of_grant(gnt);
        end else begin
            last_d = last_q;
        end
    end

    // Last-grant register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= PORT1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory (IDLE/ACCESS/RESP).
// Define DATA_MEM_RANGE_CHECK_EN to block and flag accesses with addr >= DEPTH.
module data_mem_arbiter
    import data_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] writeData,
    output logic              memRead,
    output logic              memWrite,
    input  logic [DATA_W-1:0] readData,
    output logic              err
);

`ifdef DATA_MEM_RANGE_CHECK_EN
    localparam logic RANGE_CHECK = 1'b1;
`else
    localparam logic RANGE_CHECK = 1'b0;
`endif

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic                port_q, port_d;
    logic                oor_q, oor_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic [DATA_W-1:0]   write_data_q, write_data_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic                rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                err_q, err_d;

    logic [1:0]          arb_gnt_s;
    logic                arb_advance_s;
    logic                sel_port_s;
    logic                sel_we_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;
    logic                sel_oor_s;

    rr_arbiter2 u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({req1, req0}),
        .advance (arb_advance_s),
        .gnt     (arb_gnt_s)
    );

    // Mux the winning requester's command
    always_comb begin
        sel_port_s  = port_of_grant(arb_gnt_s);
        sel_we_s    = (sel_port_s == PORT1) ? we1    : we0;
        sel_addr_s  = (sel_port_s == PORT1) ? addr1  : addr0;
        sel_wdata_s = (sel_port_s == PORT1) ? wdata1 : wdata0;
        sel_oor_s   = RANGE_CHECK & (sel_addr_s >= ADDR_W'(DEPTH));
    end

    // Next-state and registered-output logic; outputs for ACCESS are set on entry
    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        port_d        = port_q;
        oor_d         = oor_q;
        address_d     = {ADDR_W{1'b0}};
        write_data_d  = {DATA_W{1'b0}};
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
        gnt0_d        = 1'b0;
        gnt1_d        = 1'b0;
        rvalid0_d     = 1'b0;
        rvalid1_d     = 1'b0;
        rdata0_d      = rdata0_q;
        rdata1_d      = rdata1_q;
        err_d         = 1'b0;
        arb_advance_s = 1'b0;
        case (state_q)
            IDLE: begin
                arb_advance_s = 1'b1;
                if (arb_gnt_s != 2'b00) begin
                    state_d      = ACCESS;
                    we_d         = sel_we_s;
                    port_d       = sel_port_s;
                    oor_d        = sel_oor_s;
                    address_d    = sel_addr_s;
                    write_data_d = sel_wdata_s;
                    mem_read_d   = !sel_we_s && !sel_oor_s;
                    mem_write_d  = sel_we_s && !sel_oor_s;
                    gnt0_d       = (sel_port_s == PORT0);
                    gnt1_d       = (sel_port_s == PORT1);
                    err_d        = sel_oor_s;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = IDLE;
                end else begin
                    // Blocked reads return zero instead of whatever the bus shows
                    state_d = RESP;
                    if (port_q == PORT1) begin
                        rvalid1_d = 1'b1;
                        rdata1_d  = oor_q ? {DATA_W{1'b0}} : readData;
                    end else begin
                        rvalid0_d = 1'b1;
                        rdata0_d  = oor_q ? {DATA_W{1'b0}} : readData;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            port_q       <= PORT0;
            oor_q        <= 1'b0;
            address_q    <= {ADDR_W{1'b0}};
            write_data_q <= {DATA_W{1'b0}};
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rdata0_q     <= {DATA_W{1'b0}};
            rdata1_q     <= {DATA_W{1'b0}};
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            port_q       <= port_d;
            oor_q        <= oor_d;
            address_q    <= address_d;
            write_data_q <= write_data_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            err_q        <= err_d;
        end
    end

    assign address   = address_q;
    assign writeData = write_data_q;
    assign memRead   = mem_read_q;
    assign memWrite  = mem_write_q;
    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign err       = err_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural 256-word memory and a read scoreboard.
module tb_data_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, rvalid0, gnt1, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] address, writeData, readData;
    logic        memRead, memWrite, err;

    logic [31:0] mem [256];

    typedef struct {
        logic        port;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    int errors;
    int checks;

    data_mem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .gnt0      (gnt0),
        .rvalid0   (rvalid0),
        .rdata0    (rdata0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .gnt1      (gnt1),
        .rvalid1   (rvalid1),
        .rdata1    (rdata1),
        .address   (address),
        .writeData (writeData),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .readData  (readData),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: contents restored while reset is held, writes on the clock edge
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[0] <= 32'h5;
        end else if (memWrite && address < 32'd256) begin
            mem[address[7:0]] <= writeData;
        end
    end

    assign readData = !memRead ? 32'h0 :
                      (address < 32'd256) ? mem[address[7:0]] : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and check read/write exclusivity there
    task automatic tick();
        @(negedge clk);
        chk("rd_wr_excl", {31'd0, memRead & memWrite}, 32'd0);
    endtask

    task automatic drive_req(input logic port, input logic we, input logic [31:0] a, input logic [31:0] d);
        if (port) begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
        end else begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
        end
    endtask

    task automatic drop_req(input logic port);
        if (port) req1 = 1'b0;
        else      req0 = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_gnt",       {30'd0, gnt1, gnt0}, 32'd0);
        chk("rst_rvalid",    {30'd0, rvalid1, rvalid0}, 32'd0);
        chk("rst_rdata0",    rdata0, 32'd0);
        chk("rst_rdata1",    rdata1, 32'd0);
        chk("rst_address",   address, 32'd0);
        chk("rst_writeData", writeData, 32'd0);
        chk("rst_memctl",    {29'd0, err, memWrite, memRead}, 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic do_read(input logic port, input logic [31:0] a, input logic [31:0] exp_data,
                           input logic exp_err);
        exp_t e;
        tick();
        drive_req(port, 1'b0, a, 32'h0);
        e.port = port;
        e.data = exp_data;
        sb.push_back(e);
        tick();
        chk("rd_gnt",     {30'd0, gnt1, gnt0}, port ? 32'd2 : 32'd1);
        chk("rd_memRead", {31'd0, memRead}, {31'd0, !exp_err});
        chk("rd_err",     {31'd0, err}, {31'd0, exp_err});
        if (!exp_err) chk("rd_address", address, a);
        drop_req(port);
        tick();
        chk("rd_rvalid",  {30'd0, rvalid1, rvalid0}, port ? 32'd2 : 32'd1);
        chk("rd_gnt_off", {30'd0, gnt1, gnt0}, 32'd0);
        chk("rd_ctl_off", {29'd0, err, memWrite, memRead}, 32'd0);
        if (sb.size() == 0) begin
            chk("rd_sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("rd_data", e.port ? rdata1 : rdata0, e.data);
        end
    endtask

    task automatic do_write(input logic port, input logic [31:0] a, input logic [31:0] d);
        tick();
        drive_req(port, 1'b1, a, d);
        tick();
        chk("wr_gnt",       {30'd0, gnt1, gnt0}, port ? 32'd2 : 32'd1);
        chk("wr_memctl",    {30'd0, memWrite, memRead}, 32'd2);
        chk("wr_address",   address, a);
        chk("wr_writeData", writeData, d);
        drop_req(port);
        tick();
        chk("wr_memWrite_off", {31'd0, memWrite}, 32'd0);
        chk("wr_gnt_off",      {30'd0, gnt1, gnt0}, 32'd0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0;
        req1 = 1'b0; we1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0;

        apply_reset();

        // Basic read, then write/read across ports; port 0 data held through port 1 response
        do_read(1'b0, 32'd0, 32'h5, 1'b0);
        do_write(1'b0, 32'd1, 32'd10);
        do_read(1'b1, 32'd1, 32'd10, 1'b0);
        chk("rdata0_held", rdata0, 32'h5);

        // Both ports held: grants alternate starting with port 0
        apply_reset();
        tick();
        drive_req(1'b0, 1'b1, 32'd2, 32'h20);
        drive_req(1'b1, 1'b1, 32'd3, 32'h30);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_gnt", {30'd0, gnt1, gnt0}, (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("rr_wdata", writeData, (i % 2 == 0) ? 32'h20 : 32'h30);
            tick();
        end
        drop_req(1'b0);
        drop_req(1'b1);
        tick();
        chk("rr_mem2", mem[2], 32'h20);
        chk("rr_mem3", mem[3], 32'h30);

        // Reset in the ACCESS cycle of a read aborts it
        tick();
        drive_req(1'b0, 1'b0, 32'd0, 32'h0);
        tick();
        chk("abort_memRead_pre", {31'd0, memRead}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_memRead_rst", {31'd0, memRead}, 32'd0);
        chk("abort_gnt_rst",     {31'd0, gnt0}, 32'd0);
        drop_req(1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_resp", {29'd0, rvalid0, gnt0, memRead}, 32'd0);
        end
        do_read(1'b0, 32'd0, 32'h5, 1'b0);

        // Out-of-range address
`ifdef DATA_MEM_RANGE_CHECK_EN
        do_read(1'b1, 32'd300, 32'd0, 1'b1);
`else
        do_read(1'b1, 32'd300, 32'hDEAD_BEEF, 1'b0);
`endif

        chk("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
